tdm_demux4_rx: RTL
==================

// Module: tdm_demux4_rx
// PURPOSE
//  Receive end of the 4:1 time-division serial link: reassembles a slot-serial stream
//  (channel 0..3 sent one per valid beat, in the same order a 4:1 mux select sweeps)
//  into a parallel 4-channel word. Sits after the link and feeds the parallel datapath.
//  The sequential counterpart to a swept 4:1 mux: slot i is written to channel i.
// PARAMETERS
//  DATA_W   1   width of one slot/channel (bits)
// PORTS
//  clk          in   1          rising-edge clock
//  rst_n        in   1          asynchronous active-low reset
//  din_valid    in   1          din/frame_start qualified this cycle
//  frame_start  in   1          marks current beat as slot 0 (ignored unless din_valid=1)
//  din          in   DATA_W     slot data
//  dataout      out  4*DATA_W   last complete word; slot i at dataout[i*DATA_W +: DATA_W]
//  dout_valid   out  1          1-cycle pulse: dataout just updated
//  busy         out  1          1 while state=COLLECT
//  frame_err    out  1          1-cycle pulse: frame_start arrived mid-frame
//  parity_err   out  1          1-cycle pulse: parity mismatch (0 when TDM_PARITY_EN undefined)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=HUNT, slot counter=0, shadow reg=0, dataout=0,
//    dout_valid=frame_err=parity_err=0, busy=0. Reset mid-frame discards the partial frame.
//  - All outputs registered. Beats with din_valid=0 are ignored; gaps between slots allowed.
//  - FSM: HUNT, COLLECT.
//    HUNT:    din_valid&frame_start -> store din as slot 0, cnt=1, go COLLECT.
//             din_valid without frame_start -> discarded, stay HUNT.
//    COLLECT: din_valid&~frame_start -> store din at slot cnt, cnt++.
//             On last slot (cnt=3; cnt=4 with parity) -> frame complete, go HUNT, cnt=0.
//             din_valid&frame_start -> frame_err pulse next cycle, partial frame dropped,
//             din stored as new slot 0, cnt=1, stay COLLECT (resync, no dout_valid).
//  - Frame complete: dataout <= {slot3,slot2,slot1,slot0} and dout_valid=1 in the cycle
//    after the last slot beat (latency 1 clk). dataout holds value until next good frame.
//  - Every frame needs its own frame_start; back-to-back frames (new frame_start on the
//    beat right after the last slot) are accepted with no lost beat.
//  - busy follows state (registered): 1 from cycle after slot-0 beat until frame end.
// CONFIGURATION
//  TDM_PARITY_EN defined: frame has 5 slots; slot 4 = even parity = bitwise XOR of
//    slots 0..3 (DATA_W bits). Match -> dataout/dout_valid as above. Mismatch -> dataout
//    unchanged, dout_valid=0, parity_err pulses 1 cycle after slot 4 beat; FSM to HUNT.
//  TDM_PARITY_EN undefined: 4 slots, frame ends at slot 3, parity_err tied 0.
// TESTING (DATA_W=1 unless noted)
//  1 Reset: rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately, busy=0.
//  2 Basic: beats fs=1 d=1, d=1, d=0, d=1 (slots 0..3) -> dataout=4'b1011, dout_valid
//    1 cycle only, 1 clk after slot-3 beat; busy 1 during frame.
//  3 Gaps/hunt: valid beats before any frame_start ignored; frame 0,1,1,0 with
//    din_valid=0 cycles between beats -> dataout=4'b0110, single dout_valid.
//  4 Resync: fs, 1, 1, then fs with d=0, then 0,0,1 -> frame_err pulse once, no
//    dout_valid for partial, then dataout=4'b1000.
//  5 Back-to-back + reset mid-frame: two frames 4'b1011, 4'b0101 consecutive -> two
//    dout_valid pulses 4 beats apart; rst_n low after slot 2 of a third frame ->
//    dataout=0, frame not completed.
//  6 TDM_PARITY_EN, DATA_W=2: slots 2'b01,2'b10,2'b11,2'b00, parity 2'b00 ->
//    dataout=8'b00111001, dout_valid; same with parity 2'b01 -> parity_err, dataout held.

Source files
------------

// File: rtl/tdm_demux4_rx_if.sv
// Slot-serial link into the 4:1 TDM receiver, plus the parallel word and status it produces.
interface tdm_demux4_rx_if #(
    parameter int DATA_W = 1
);
    logic                  din_valid;
    logic                  frame_start;
    logic [DATA_W-1:0]     din;
    logic [4*DATA_W-1:0]   dataout;
    logic                  dout_valid;
    logic                  busy;
    logic                  frame_err;
    logic                  parity_err;

    modport master (
        output din_valid, frame_start, din,
        input  dataout, dout_valid, busy, frame_err, parity_err
    );

    modport slave (
        input  din_valid, frame_start, din,
        output dataout, dout_valid, busy, frame_err, parity_err
    );
endinterface

// File: rtl/tdm_demux4_rx.sv
// 4:1 TDM receiver: reassembles slot-serial beats into a 4-channel parallel word.
// Optional TDM_PARITY_EN adds a fifth even-parity slot checked before the word is published.
//
// state   | meaning
// HUNT    | waiting for a valid beat with frame_start (slot 0)
// COLLECT | slot 0 captured, gathering the remaining slots
module tdm_demux4_rx #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    tdm_demux4_rx_if.slave    link
);
    localparam logic [0:0] HUNT    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

`ifdef TDM_PARITY_EN
    localparam logic [2:0] LAST_SLOT = 3'd4;
    localparam int         NSTORE    = 4;
`else
    localparam logic [2:0] LAST_SLOT = 3'd3;
    localparam int         NSTORE    = 3;
`endif

    logic [0:0]               state;
    logic [2:0]               cnt;
    logic [NSTORE*DATA_W-1:0] shadow;
    logic [4*DATA_W-1:0]      dataout_r;
    logic                     dout_valid_r;
    logic                     frame_err_r;

`ifdef TDM_PARITY_EN
    logic              parity_err_r;
    logic [DATA_W-1:0] par_calc;

    always_comb begin
        par_calc = '0;
        for (int i = 0; i < 4; i++) begin
            par_calc = par_calc ^ shadow[i*DATA_W +: DATA_W];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HUNT;
            cnt          <= 3'd0;
            shadow       <= '0;
            dataout_r    <= '0;
            dout_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
`ifdef TDM_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            dout_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
`ifdef TDM_PARITY_EN
            parity_err_r <= 1'b0;
`endif
            if (link.din_valid) begin
                case (state)
                    HUNT: begin
                        if (link.frame_start) begin
                            shadow[DATA_W-1:0] <= link.din;
                            cnt                <= 3'd1;
                            state              <= COLLECT;
                        end
                    end
                    default: begin
                        if (link.frame_start) begin
                            // resync: drop the partial frame, this beat is the new slot 0
                            frame_err_r        <= 1'b1;
                            shadow[DATA_W-1:0] <= link.din;
                            cnt                <= 3'd1;
                        end else if (cnt == LAST_SLOT) begin
                            state <= HUNT;
                            cnt   <= 3'd0;
`ifdef TDM_PARITY_EN
                            if (link.din == par_calc) begin
                                dataout_r    <= shadow;
                                dout_valid_r <= 1'b1;
                            end else begin
                                parity_err_r <= 1'b1;
                            end
`else
                            dataout_r    <= {link.din, shadow};
                            dout_valid_r <= 1'b1;
`endif
                        end else begin
                            for (int i = 0; i < NSTORE; i++) begin
                                if (cnt == 3'(i)) begin
                                    shadow[i*DATA_W +: DATA_W] <= link.din;
                                end
                            end
                            cnt <= cnt + 3'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign link.dataout    = dataout_r;
    assign link.dout_valid = dout_valid_r;
    assign link.busy       = (state == COLLECT);
    assign link.frame_err  = frame_err_r;
`ifdef TDM_PARITY_EN
    assign link.parity_err = parity_err_r;
`else
    assign link.parity_err = 1'b0;
`endif

endmodule
